// File: rtl/mcu_8bit_fetch_unit_if.sv
// Signal bundle between the mcu_8bit fetch unit, the decode/execute core and program memory.
// The master modport is the fetch unit's view; the slave modport is the core/memory side.
interface mcu_8bit_fetch_unit_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
);
  logic [ADDR_W-1:0] reset_pc_i;
  logic              halt_i;
  logic              branch_en_i;
  logic [ADDR_W-1:0] branch_target_i;
  logic              mem_rd_en_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [DATA_W-1:0] mem_rdata_i;
  logic              mem_rvalid_i;
  logic [DATA_W-1:0] instr_data_o;
  logic [ADDR_W-1:0] instr_pc_o;
  logic              instr_valid_o;
  logic              instr_ready_i;
  logic [ADDR_W-1:0] current_pc_o;
  logic              fetch_err_o;

  modport master (
    input  reset_pc_i, halt_i, branch_en_i, branch_target_i,
    input  mem_rdata_i, mem_rvalid_i, instr_ready_i,
    output mem_rd_en_o, mem_addr_o, instr_data_o, instr_pc_o, instr_valid_o,
    output current_pc_o, fetch_err_o
  );

  modport slave (
    output reset_pc_i, halt_i, branch_en_i, branch_target_i,
    output mem_rdata_i, mem_rvalid_i, instr_ready_i,
    input  mem_rd_en_o, mem_addr_o, instr_data_o, instr_pc_o, instr_valid_o,
    input  current_pc_o, fetch_err_o
  );
endinterface

// File: rtl/mcu_8bit_fetch_unit.sv
// Instruction fetch stage of mcu_8bit: owns the PC, issues single outstanding memory reads and
// presents instructions over valid/ready. Optional macro FETCH_WRAP_TRAP_EN adds the pc_wrap trap.
module mcu_8bit_fetch_unit #(
  parameter int ADDR_W      = 8,
  parameter int DATA_W      = 8,
  parameter int TIMEOUT_CYC = 15
) (
  input  logic                  clk,
  input  logic                  rst_n,
  mcu_8bit_fetch_unit_if.master bus
`ifdef FETCH_WRAP_TRAP_EN
  ,
  output logic                  pc_wrap_o
`endif
);

  localparam logic [2:0] LOAD  = 3'd0;
  localparam logic [2:0] REQ   = 3'd1;
  localparam logic [2:0] WAIT  = 3'd2;
  localparam logic [2:0] VALID = 3'd3;
  localparam logic [2:0] FLUSH = 3'd4;
  localparam logic [2:0] HALT  = 3'd5;

  localparam int CNT_W = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC + 1);
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYC - 1);

  logic [2:0]        state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] ipc_q, ipc_d;
  logic [DATA_W-1:0] idata_q, idata_d;
  logic              ivalid_q, ivalid_d;
  logic              err_q, err_d;
  logic [CNT_W-1:0]  tmo_q, tmo_d;
  logic              issue;
  logic              handshake;
  logic              tmo_hit;
`ifdef FETCH_WRAP_TRAP_EN
  logic              wrap_q, wrap_d;
`endif

  assign handshake = ivalid_q & bus.instr_ready_i;
  assign tmo_hit   = (tmo_q == TMO_LAST);

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    ipc_d    = ipc_q;
    idata_d  = idata_q;
    ivalid_d = ivalid_q;
    err_d    = err_q;
    tmo_d    = tmo_q;
    issue    = 1'b0;
`ifdef FETCH_WRAP_TRAP_EN
    wrap_d   = wrap_q;
`endif
    case (state_q)
      LOAD: begin
        pc_d    = bus.reset_pc_i;
        state_d = REQ;
      end
      REQ: begin
        if (bus.branch_en_i) begin
          pc_d = bus.branch_target_i;
        end else if (!bus.halt_i) begin
          issue   = 1'b1;
          tmo_d   = '0;
          state_d = WAIT;
        end
      end
      // A redirect while a read is in flight keeps the request alive as FLUSH so its
      // response is swallowed; the timeout keeps counting against the same request.
      WAIT, FLUSH: begin
        if (bus.branch_en_i) begin
          pc_d = bus.branch_target_i;
        end
        if (bus.mem_rvalid_i) begin
          if (state_q == WAIT && !bus.branch_en_i) begin
            idata_d  = bus.mem_rdata_i;
            ipc_d    = pc_q;
            pc_d     = pc_q + 1'b1;
            ivalid_d = 1'b1;
            state_d  = VALID;
`ifdef FETCH_WRAP_TRAP_EN
            if (&pc_q) begin
              wrap_d = 1'b1;
            end
`endif
          end else begin
            state_d = REQ;
          end
        end else if (tmo_hit) begin
          err_d   = 1'b1;
          state_d = HALT;
        end else begin
          tmo_d = tmo_q + 1'b1;
          if (bus.branch_en_i) begin
            state_d = FLUSH;
          end
        end
      end
      VALID: begin
        if (bus.branch_en_i) begin
          pc_d     = bus.branch_target_i;
          ivalid_d = 1'b0;
          state_d  = REQ;
        end else if (handshake) begin
          ivalid_d = 1'b0;
`ifdef FETCH_WRAP_TRAP_EN
          state_d  = (&ipc_q) ? HALT : REQ;
`else
          state_d  = REQ;
`endif
        end
      end
      HALT: begin
        state_d = HALT;
      end
      default: begin
        state_d = LOAD;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= LOAD;
      pc_q     <= '0;
      ipc_q    <= '0;
      idata_q  <= '0;
      ivalid_q <= 1'b0;
      err_q    <= 1'b0;
      tmo_q    <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      ipc_q    <= ipc_d;
      idata_q  <= idata_d;
      ivalid_q <= ivalid_d;
      err_q    <= err_d;
      tmo_q    <= tmo_d;
    end
  end

`ifdef FETCH_WRAP_TRAP_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wrap_q <= 1'b0;
    end else begin
      wrap_q <= wrap_d;
    end
  end

  assign pc_wrap_o = wrap_q;
`endif

  assign bus.mem_rd_en_o   = issue;
  assign bus.mem_addr_o    = pc_q;
  assign bus.instr_data_o  = idata_q;
  assign bus.instr_pc_o    = ipc_q;
  assign bus.instr_valid_o = ivalid_q;
  assign bus.current_pc_o  = pc_q;
  assign bus.fetch_err_o   = err_q;

endmodule

// File: tb/tb_mcu_8bit_fetch_unit.sv
// Self-checking bench for mcu_8bit_fetch_unit: directed scenarios plus random traffic against a
// transaction-level model of the fetch stream, memory responder and timeout.
module tb_mcu_8bit_fetch_unit;
  localparam int TO = 15;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
`ifdef FETCH_WRAP_TRAP_EN
  logic pcWrap;
`endif

  mcu_8bit_fetch_unit_if #(.ADDR_W(8), .DATA_W(8)) bus ();

  mcu_8bit_fetch_unit #(.ADDR_W(8), .DATA_W(8), .TIMEOUT_CYC(TO)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
`ifdef FETCH_WRAP_TRAP_EN
    ,
    .pc_wrap_o (pcWrap)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Behavioural model state
  bit mLoad = 1, mOut = 0, mStale = 0, mPres = 0, mHalted = 0, mErr = 0, mWrap = 0;
  int mAge = 0;
  logic [7:0] mPc = 0, mOutAddr = 0, mPresPc = 0, mPresData = 0;

  // Memory responder
  logic [7:0] memArr [256];
  int lat = 1;
  bit latRand = 0;
  bit spurEn = 0;
  bit forceAA = 0;
  int cnt = 0;
  logic [7:0] reqAddr = 0;

  int hsPc [$];
  int hsData [$];
  int hsCyc [$];
  int rdAddr [$];
  int rdCyc [$];
  int errCyc = -1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic applyStimulus(input bit h, input bit b, input logic [7:0] t, input bit r);
    @(posedge clk);
    #1;
    bus.halt_i          = h;
    bus.branch_en_i     = b;
    bus.branch_target_i = t;
    bus.instr_ready_i   = r;
  endtask

  task automatic doReset(input logic [7:0] pc, input int n);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    bus.reset_pc_i = pc;
    hsPc.delete(); hsData.delete(); hsCyc.delete(); rdAddr.delete(); rdCyc.delete();
    errCyc = -1;
    repeat (n) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic waitValid(input string name);
    int n = 0;
    while (!bus.instr_valid_o && n < 30) begin
      @(negedge clk);
      n++;
    end
    checkOutput(name, {31'd0, bus.instr_valid_o}, 32'd1);
  endtask

  task automatic waitRd(input string name);
    int base = rdAddr.size();
    int n = 0;
    while (rdAddr.size() == base && n < 30) begin
      @(negedge clk);
      n++;
    end
    checkOutput(name, {31'd0, rdAddr.size() > base}, 32'd1);
  endtask

  // Compare process: checks every cycle, then steps memory and model for the coming edge.
  always @(negedge clk) begin
    bit predRd, br, rv;
    cyc++;
    if (!rst_n) begin
      checkOutput("rst_rd_en", {31'd0, bus.mem_rd_en_o}, 0);
      checkOutput("rst_mem_addr", {24'd0, bus.mem_addr_o}, 0);
      checkOutput("rst_instr_data", {24'd0, bus.instr_data_o}, 0);
      checkOutput("rst_instr_pc", {24'd0, bus.instr_pc_o}, 0);
      checkOutput("rst_instr_valid", {31'd0, bus.instr_valid_o}, 0);
      checkOutput("rst_current_pc", {24'd0, bus.current_pc_o}, 0);
      checkOutput("rst_fetch_err", {31'd0, bus.fetch_err_o}, 0);
`ifdef FETCH_WRAP_TRAP_EN
      checkOutput("rst_pc_wrap", {31'd0, pcWrap}, 0);
`endif
      mLoad = 1; mOut = 0; mStale = 0; mPres = 0; mHalted = 0; mErr = 0; mWrap = 0;
      mAge = 0; mPc = 0;
      cnt = 0;
      bus.mem_rvalid_i = 1'b0;
    end else begin
      predRd = !mLoad && !mHalted && !mOut && !mPres && !bus.halt_i && !bus.branch_en_i;
      checkOutput("rd_en", {31'd0, bus.mem_rd_en_o}, {31'd0, predRd});
      if (predRd) checkOutput("mem_addr", {24'd0, bus.mem_addr_o}, {24'd0, mPc});
      checkOutput("current_pc", {24'd0, bus.current_pc_o}, {24'd0, mPc});
      checkOutput("instr_valid", {31'd0, bus.instr_valid_o}, {31'd0, mPres});
      if (mPres) begin
        checkOutput("instr_pc", {24'd0, bus.instr_pc_o}, {24'd0, mPresPc});
        checkOutput("instr_data", {24'd0, bus.instr_data_o}, {24'd0, mPresData});
      end
      checkOutput("fetch_err", {31'd0, bus.fetch_err_o}, {31'd0, mErr});
`ifdef FETCH_WRAP_TRAP_EN
      checkOutput("pc_wrap", {31'd0, pcWrap}, {31'd0, mWrap});
`endif
      if (bus.instr_valid_o && bus.instr_ready_i) begin
        hsPc.push_back(int'(bus.instr_pc_o));
        hsData.push_back(int'(bus.instr_data_o));
        hsCyc.push_back(cyc);
      end
      if (bus.mem_rd_en_o) begin
        rdAddr.push_back(int'(bus.mem_addr_o));
        rdCyc.push_back(cyc);
      end
      if (bus.fetch_err_o && errCyc < 0) errCyc = cyc;

      bus.mem_rvalid_i = 1'b0;
      if (cnt > 0) begin
        cnt--;
        if (cnt == 0) begin
          bus.mem_rvalid_i = 1'b1;
          bus.mem_rdata_i  = forceAA ? 8'hAA : memArr[reqAddr];
          forceAA = 0;
        end
      end else if (spurEn && $urandom_range(9) == 0) begin
        bus.mem_rvalid_i = 1'b1;
        bus.mem_rdata_i  = 8'($urandom);
      end
      if (bus.mem_rd_en_o && lat > 0) begin
        cnt = latRand ? int'($urandom_range(4, 1)) : lat;
        reqAddr = bus.mem_addr_o;
      end

      br = bus.branch_en_i;
      rv = bus.mem_rvalid_i;
      if (mLoad) begin
        mPc = bus.reset_pc_i;
        mLoad = 0;
      end else if (!mHalted) begin
        if (predRd) begin
          mOut = 1; mStale = 0; mAge = 0; mOutAddr = mPc;
        end else if (mOut) begin
          if (br) mPc = bus.branch_target_i;
          if (rv) begin
            mOut = 0;
            if (!mStale && !br) begin
              mPres = 1;
              mPresPc = mOutAddr;
              mPresData = bus.mem_rdata_i;
              mPc = mOutAddr + 8'd1;
              if (mOutAddr == 8'hFF) mWrap = 1;
            end
          end else begin
            mAge++;
            if (mAge == TO) begin
              mErr = 1; mHalted = 1; mOut = 0;
            end else if (br) begin
              mStale = 1;
            end
          end
        end else if (mPres) begin
          if (br) begin
            mPres = 0;
            mPc = bus.branch_target_i;
          end else if (bus.instr_ready_i) begin
            mPres = 0;
`ifdef FETCH_WRAP_TRAP_EN
            if (mPresPc == 8'hFF) mHalted = 1;
`endif
          end
        end else if (br) begin
          mPc = bus.branch_target_i;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int base, rdBase, hsBase, aaSeen, zeroFetched;
    logic [7:0] snapPc, snapData;
    for (int i = 0; i < 256; i++) begin
      memArr[i] = 8'($urandom);
      if (memArr[i] == 8'hAA) memArr[i] = 8'h55;
    end
    bus.halt_i = 0; bus.branch_en_i = 0; bus.branch_target_i = 0; bus.instr_ready_i = 1;
    bus.mem_rvalid_i = 0; bus.mem_rdata_i = 0; bus.reset_pc_i = 8'h10;

    // 1: reset, then sequential fetch with 1-cycle memory
    repeat (20) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (12) @(negedge clk);
    checkOutput("p1_first_addr", rdAddr.size() > 0 ? rdAddr[0] : -1, 32'h10);
    checkOutput("p1_hs_count", {31'd0, hsPc.size() >= 3}, 1);
    if (hsPc.size() >= 3) begin
      checkOutput("p1_hs_pc0", hsPc[0], 32'h10);
      checkOutput("p1_hs_pc1", hsPc[1], 32'h11);
      checkOutput("p1_hs_pc2", hsPc[2], 32'h12);
      checkOutput("p1_interval01", hsCyc[1] - hsCyc[0], 3);
      checkOutput("p1_interval12", hsCyc[2] - hsCyc[1], 3);
    end

    // 2: core stalls for 5 cycles
    applyStimulus(0, 0, 0, 0);
    waitValid("p2_wait_valid");
    snapPc = bus.instr_pc_o;
    snapData = bus.instr_data_o;
    rdBase = rdAddr.size();
    repeat (5) @(negedge clk);
    checkOutput("p2_no_rd", rdAddr.size(), rdBase);
    checkOutput("p2_pc_stable", {24'd0, bus.instr_pc_o}, {24'd0, snapPc});
    checkOutput("p2_data_stable", {24'd0, bus.instr_data_o}, {24'd0, snapData});
    checkOutput("p2_current_pc", {24'd0, bus.current_pc_o}, {24'd0, snapPc + 8'd1});

    // 3: branch during WAIT, the in-flight 0xAA response must be dropped
    lat = 3;
    forceAA = 1;
    hsBase = hsPc.size();
    applyStimulus(0, 0, 0, 1);
    waitRd("p3_wait_rd");
    rdBase = rdAddr.size();
    applyStimulus(0, 1, 8'h80, 1);
    applyStimulus(0, 0, 0, 1);
    repeat (14) @(negedge clk);
    aaSeen = 0;
    for (int i = hsBase; i < hsData.size(); i++) if (hsData[i] == 8'hAA) aaSeen = 1;
    checkOutput("p3_aa_dropped", aaSeen, 0);
    checkOutput("p3_next_addr", rdAddr.size() > rdBase ? rdAddr[rdBase] : -1, 32'h80);
    checkOutput("p3_next_hs_pc", hsPc.size() > hsBase + 1 ? hsPc[hsBase + 1] : -1, 32'h80);

    // 4: memory never answers
    applyStimulus(0, 0, 0, 0);
    waitValid("p4_wait_valid");
    lat = 0;
    errCyc = -1;
    applyStimulus(0, 0, 0, 1);
    waitRd("p4_wait_rd");
    base = 0;
    while (errCyc < 0 && base < 40) begin
      @(negedge clk);
      base++;
    end
    checkOutput("p4_err_seen", {31'd0, errCyc >= 0}, 1);
    checkOutput("p4_err_delay", errCyc - rdCyc[rdCyc.size() - 1], 16);
    rdBase = rdAddr.size();
    repeat (10) @(negedge clk);
    checkOutput("p4_no_rd_after_err", rdAddr.size(), rdBase);
    checkOutput("p4_err_sticky", {31'd0, bus.fetch_err_o}, 1);
    lat = 1;
    doReset(8'hFE, 3);
    @(negedge clk);
    checkOutput("p4_err_cleared", {31'd0, bus.fetch_err_o}, 0);

    // 5: PC wrap from 0xFE
    repeat (20) @(negedge clk);
`ifdef FETCH_WRAP_TRAP_EN
    checkOutput("p5_hs_count", hsPc.size(), 2);
    checkOutput("p5_pc_wrap", {31'd0, pcWrap}, 1);
    zeroFetched = 0;
    for (int i = 0; i < rdAddr.size(); i++) if (rdAddr[i] == 0) zeroFetched = 1;
    checkOutput("p5_no_fetch_00", zeroFetched, 0);
`else
    checkOutput("p5_hs_count", {31'd0, hsPc.size() >= 4}, 1);
    if (hsPc.size() >= 4) begin
      checkOutput("p5_hs_pc0", hsPc[0], 32'hFE);
      checkOutput("p5_hs_pc1", hsPc[1], 32'hFF);
      checkOutput("p5_hs_pc2", hsPc[2], 32'h00);
      checkOutput("p5_hs_pc3", hsPc[3], 32'h01);
    end
`endif

    // 6: halt raised while an instruction is presented
    doReset(8'h40, 2);
    applyStimulus(0, 0, 0, 0);
    waitValid("p6_wait_valid");
    hsBase = hsPc.size();
    applyStimulus(1, 0, 0, 1);
    rdBase = rdAddr.size();
    repeat (6) @(negedge clk);
    checkOutput("p6_handshake", hsPc.size(), hsBase + 1);
    checkOutput("p6_no_rd_halted", rdAddr.size(), rdBase);
    applyStimulus(0, 0, 0, 1);
    repeat (3) @(negedge clk);
    checkOutput("p6_rd_resumes", {31'd0, rdAddr.size() > rdBase}, 1);

    // 7: random traffic with random latency, spurious strobes and a mid-run reset
    latRand = 1;
    spurEn = 1;
    doReset(8'($urandom), 2);
    for (int i = 0; i < 2500; i++) begin
      applyStimulus($urandom_range(7) == 0, $urandom_range(9) == 0, 8'($urandom),
                    $urandom_range(3) != 0);
      if (i == 1200) begin
        #2 rst_n = 1'b0;
        bus.reset_pc_i = 8'($urandom);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
      end
    end
    applyStimulus(0, 0, 0, 1);
    repeat (5) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
